// File: rtl/poly_stream_tx_pkg.sv
// Shared types for the FV polynomial stream transmitter: FSM states, coefficient type, counter width.
package fv_pkg;

  localparam int N_DEF  = 16;
  localparam int QW_DEF = 64;

  typedef logic [QW_DEF-1:0] coeff_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ptx_state_t;

  // Index width for an N-entry buffer; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/poly_stream_tx_if.sv
// Coefficient stream bus: data/vld/last flow from the transmitter, rdy flows back from the sink.
// A beat transfers on a rising edge where vld && rdy; once vld is high, data/last stay stable and
// vld stays high until that transfer happens.
interface axis_if #(
  parameter int QW = 64
);
  logic [QW-1:0] data;
  logic          vld;
  logic          last;
  logic          rdy;

  modport master (output data, vld, last, input  rdy);
  modport slave  (input  data, vld, last, output rdy);
  modport out    (output data, vld, last, input  rdy);
  modport in     (input  data, vld, last, output rdy);
endinterface

// File: rtl/poly_coeff_mem.sv
// N x QW coefficient buffer: one synchronous write port, one combinational read port, no reset.
module poly_coeff_mem
  import fv_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int QW = QW_DEF,
  localparam int AW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [QW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [QW-1:0] rd_data
);

  logic [QW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/poly_stream_tx.sv
// Streams one buffered polynomial (N coeffs, QW bits) over axis_if, 1 coeff/clk, coeff 0 first.
// Optional PTX_XSHIFT_EN adds the xshift port: output becomes the poly times x^k mod (x^N+1).
module poly_stream_tx
  import fv_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int QW = QW_DEF,
  localparam int CW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          s_rst,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_addr,
  input  logic [QW-1:0] wr_data,
  input  logic          start,
`ifdef PTX_XSHIFT_EN
  input  logic [CW-1:0] xshift,
`endif
  output logic          busy,
  output logic          done,
  output logic          wr_err,
  output ptx_state_t    dbg_state,
  axis_if.out           s
);

  ptx_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] rd_idx;
  logic [CW-1:0] rd_addr;
  logic [QW-1:0] rd_data;
  logic [QW-1:0] mem_word;
  logic [QW-1:0] beat_data;
  logic          wr_acc;
  logic          beat_acc;

  assign wr_acc    = wr_en && (state == ST_IDLE);
  assign beat_acc  = s.vld && s.rdy;
  assign dbg_state = state;

  // cnt is the index of the beat sitting in the output register; fetch the one after it.
  assign rd_idx = (state == ST_IDLE) ? '0 : cnt + CW'(1);

`ifdef PTX_XSHIFT_EN
  logic [CW-1:0] k_q;
  logic [CW-1:0] shift_k;
  logic          neg;

  assign shift_k   = (state == ST_IDLE) ? xshift : k_q;
  assign rd_addr   = rd_idx - shift_k;
  assign neg       = rd_idx < shift_k;
  assign beat_data = neg ? ({QW{1'b0}} - mem_word) : mem_word;
`else
  assign rd_addr   = rd_idx;
  assign beat_data = mem_word;
`endif

  // A write landing in the same cycle as start must be visible in beat 0.
  assign mem_word = (wr_acc && (wr_addr == rd_addr)) ? wr_data : rd_data;

  poly_coeff_mem #(
    .N  (N),
    .QW (QW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      s.vld  <= 1'b0;
      s.last <= 1'b0;
      s.data <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      wr_err <= 1'b0;
`ifdef PTX_XSHIFT_EN
      k_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (wr_en && (state == ST_STREAM)) wr_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_STREAM;
            busy   <= 1'b1;
            cnt    <= '0;
            s.vld  <= 1'b1;
            s.last <= 1'b0;
            s.data <= beat_data;
            wr_err <= 1'b0;
`ifdef PTX_XSHIFT_EN
            k_q    <= xshift;
`endif
          end
        end
        ST_STREAM: begin
          // vld is always high here, so "!vld || rdy" collapses to an accepted beat.
          if (beat_acc) begin
            if (s.last) begin
              state  <= ST_IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
              cnt    <= '0;
              s.vld  <= 1'b0;
              s.last <= 1'b0;
            end else begin
              cnt    <= rd_idx;
              s.data <= beat_data;
              s.last <= (rd_idx == CW'(N - 1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_stream_tx.sv
// Self-checking bench for poly_stream_tx: randomized loads and backpressure against a polynomial model.
// Build with PTX_XSHIFT_EN defined to also exercise the negacyclic shift.
module tb_poly_stream_tx;
  import fv_pkg::*;

  localparam int N  = 16;
  localparam int QW = 64;
  localparam int CW = cnt_w(N);

  logic          clk = 1'b0;
  logic          s_rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [CW-1:0] wr_addr = '0;
  logic [QW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [CW-1:0] xshift = '0;
  logic          busy, done, wr_err;
  ptx_state_t    dbg_state;

  axis_if #(.QW(QW)) s ();

  poly_stream_tx #(.N(N), .QW(QW)) dut (
    .clk       (clk),
    .s_rst     (s_rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
`ifdef PTX_XSHIFT_EN
    .xshift    (xshift),
`endif
    .busy      (busy),
    .done      (done),
    .wr_err    (wr_err),
    .dbg_state (dbg_state),
    .s         (s)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [QW-1:0] mem_m [N];
  logic [QW-1:0] exp_q [$];
  logic [QW-1:0] got_d [$];
  bit            got_l [$];

  // Coefficient i of x^k * p(x) mod (x^N + 1), mod 2^QW.
  function automatic logic [QW-1:0] model_beat(input int i, input int k);
    int idx;
    idx = ((i - k) % N + N) % N;
    return (i >= k) ? mem_m[idx] : (64'd0 - mem_m[idx]);
  endfunction

  task automatic build_exp(input int k);
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(model_beat(i, k));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    s_rst = 1'b1; s.rdy = 1'b0; wr_en = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 s_rst = 1'b0;
  endtask

  task automatic write_coeff(input int addr, input logic [QW-1:0] data);
    wr_en = 1'b1; wr_addr = CW'(addr); wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mem_m[addr] = data;
  endtask

  task automatic load_mem(input int mode);
    for (int i = 0; i < N; i++)
      write_coeff(i, (mode == 0) ? QW'(i + 1) : {$urandom, $urandom});
  endtask

  task automatic start_stream(input int k);
    start = 1'b1; xshift = CW'(k);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives rdy (0: always, 1: 1,0,0 repeating, 2: random) and records accepted beats
  // until the last one is taken; counts cycles and hold violations under backpressure.
  task automatic collect(input int mode, input int budget, output int cycles,
                         output int hold_err, output bit timed_out);
    logic [QW-1:0] pd;
    logic          pl, pend, r;
    got_d.delete(); got_l.delete();
    hold_err = 0; cycles = 0; pend = 1'b0; timed_out = 1'b1; pd = '0; pl = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (pend && (s.vld !== 1'b1 || s.data !== pd || s.last !== pl)) hold_err++;
      case (mode)
        0:       r = 1'b1;
        1:       r = (c % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      s.rdy = r;
      pend = s.vld && !r; pd = s.data; pl = s.last;
      if (s.vld && r) begin got_d.push_back(s.data); got_l.push_back(s.last); end
      @(posedge clk); #1;
      cycles++;
      if (got_l.size() > 0 && got_l[got_l.size()-1]) begin timed_out = 1'b0; break; end
    end
    s.rdy = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (s.vld !== 1'b0)  begin n_bad++; $display("FAIL reset_vld: got %b want 0", s.vld); end
    n_cmp++; if (s.last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", s.last); end
    n_cmp++; if (s.data !== '0)   begin n_bad++; $display("FAIL reset_data: got %h want 0", s.data); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
  endtask

  task automatic test_basic();
    int cyc, herr; bit to;
    load_mem(0); build_exp(0);
    start_stream(0);
    n_cmp++; if (s.vld !== 1'b1 || s.data !== exp_q[0]) begin n_bad++; $display("FAIL basic_first: vld %b data %h want 1 %h", s.vld, s.data, exp_q[0]); end
    n_cmp++; if (busy !== 1'b1 || dbg_state !== ST_STREAM) begin n_bad++; $display("FAIL basic_busy: busy %b state %0d want 1 STREAM", busy, dbg_state); end
    collect(0, 64, cyc, herr, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL basic_timeout: last beat never accepted"); end
    n_cmp++; if (got_d.size() != N || cyc != N) begin n_bad++; $display("FAIL basic_count: beats %0d cycles %0d want %0d", got_d.size(), cyc, N); end
    for (int i = 0; i < got_d.size() && i < N; i++) begin
      n_cmp++; if (got_d[i] !== exp_q[i] || got_l[i] !== (i == N - 1)) begin n_bad++; $display("FAIL basic_beat%0d: data %h last %b want %h %b", i, got_d[i], got_l[i], exp_q[i], i == N - 1); end
    end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || s.vld !== 1'b0) begin n_bad++; $display("FAIL basic_end: done %b busy %b vld %b want 1 0 0", done, busy, s.vld); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_backpressure(input int mode, input int fill);
    int cyc, herr; bit to;
    load_mem(fill); build_exp(0);
    start_stream(0);
    collect(mode, 400, cyc, herr, to);
    n_cmp++; if (to || got_d.size() != N) begin n_bad++; $display("FAIL bp%0d_count: beats %0d timeout %b want %0d 0", mode, got_d.size(), to, N); end
    n_cmp++; if (herr != 0) begin n_bad++; $display("FAIL bp%0d_hold: %0d unstable cycles want 0", mode, herr); end
    for (int i = 0; i < got_d.size() && i < N; i++) begin
      n_cmp++; if (got_d[i] !== exp_q[i] || got_l[i] !== (i == N - 1)) begin n_bad++; $display("FAIL bp%0d_beat%0d: data %h last %b want %h %b", mode, i, got_d[i], got_l[i], exp_q[i], i == N - 1); end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL bp%0d_done: got %b want 1", mode, done); end
  endtask

  task automatic test_wr_err();
    int cyc, herr; bit to;
    load_mem(1); build_exp(0);
    start_stream(0);
    wr_en = 1'b1; wr_addr = CW'(3); wr_data = 64'hDEAD; s.rdy = 1'b0;
    @(posedge clk); #1;
    wr_en = 1'b0;
    n_cmp++; if (wr_err !== 1'b1) begin n_bad++; $display("FAIL wrerr_set: got %b want 1", wr_err); end
    collect(2, 400, cyc, herr, to);
    n_cmp++; if (to || got_d.size() != N) begin n_bad++; $display("FAIL wrerr_count: beats %0d want %0d", got_d.size(), N); end
    for (int i = 0; i < got_d.size() && i < N; i++) begin
      n_cmp++; if (got_d[i] !== exp_q[i]) begin n_bad++; $display("FAIL wrerr_beat%0d: got %h want %h", i, got_d[i], exp_q[i]); end
    end
    n_cmp++; if (wr_err !== 1'b1) begin n_bad++; $display("FAIL wrerr_sticky: got %b want 1", wr_err); end
    @(posedge clk); #1;
    start_stream(0);
    n_cmp++; if (wr_err !== 1'b0) begin n_bad++; $display("FAIL wrerr_clear: got %b want 0", wr_err); end
    collect(0, 64, cyc, herr, to);
    n_cmp++; if (to || got_d.size() != N) begin n_bad++; $display("FAIL replay_count: beats %0d want %0d", got_d.size(), N); end
    for (int i = 0; i < got_d.size() && i < N; i++) begin
      n_cmp++; if (got_d[i] !== exp_q[i]) begin n_bad++; $display("FAIL replay_beat%0d: got %h want %h", i, got_d[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, herr; bit to;
    load_mem(1); build_exp(0);
    start_stream(0);
    s.rdy = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    n_cmp++; if (s.data !== exp_q[5]) begin n_bad++; $display("FAIL rstmid_pre: got %h want %h", s.data, exp_q[5]); end
    s_rst = 1'b1;
    @(posedge clk); #1;
    s_rst = 1'b0; s.rdy = 1'b0;
    n_cmp++; if (s.vld !== 1'b0 || s.last !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_abort: vld %b last %b busy %b done %b want 0 0 0 0", s.vld, s.last, busy, done); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0 || s.vld !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet%0d: done %b vld %b want 0 0", c, done, s.vld); end
    end
    start_stream(0);
    collect(2, 400, cyc, herr, to);
    n_cmp++; if (to || got_d.size() != N) begin n_bad++; $display("FAIL rstmid_count: beats %0d want %0d", got_d.size(), N); end
    for (int i = 0; i < got_d.size() && i < N; i++) begin
      n_cmp++; if (got_d[i] !== exp_q[i]) begin n_bad++; $display("FAIL rstmid_beat%0d: got %h want %h", i, got_d[i], exp_q[i]); end
    end
  endtask

  task automatic test_write_with_start();
    int cyc, herr; bit to;
    logic [QW-1:0] v;
    load_mem(1);
    v = {$urandom, $urandom};
    wr_en = 1'b1; wr_addr = '0; wr_data = v; start = 1'b1; xshift = '0;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    mem_m[0] = v;
    build_exp(0);
    n_cmp++; if (s.data !== v) begin n_bad++; $display("FAIL wstart_beat0: got %h want %h", s.data, v); end
    collect(2, 400, cyc, herr, to);
    n_cmp++; if (to || got_d.size() != N) begin n_bad++; $display("FAIL wstart_count: beats %0d want %0d", got_d.size(), N); end
    for (int i = 0; i < got_d.size() && i < N; i++) begin
      n_cmp++; if (got_d[i] !== exp_q[i]) begin n_bad++; $display("FAIL wstart_beat%0d: got %h want %h", i, got_d[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit exp_v;
    load_mem(1); build_exp(0);
    s.rdy = 1'b1; start = 1'b1; xshift = '0;
    @(posedge clk); #1;
    // Expected trace: N beats, one idle cycle carrying done, then N more beats.
    for (int c = 0; c <= 2 * N; c++) begin
      exp_v = (c != N);
      n_cmp++; if (s.vld !== exp_v) begin n_bad++; $display("FAIL b2b_vld%0d: got %b want %b", c, s.vld, exp_v); end
      if (exp_v) begin
        n_cmp++; if (s.data !== exp_q[c % (N + 1)] || s.last !== ((c % (N + 1)) == N - 1))
          begin n_bad++; $display("FAIL b2b_beat%0d: data %h last %b want %h", c, s.data, s.last, exp_q[c % (N + 1)]); end
      end else begin
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_gap: got %b want 1", done); end
      end
      if (c == 2 * N) start = 1'b0;
      @(posedge clk); #1;
    end
    s.rdy = 1'b0;
    n_cmp++; if (s.vld !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL b2b_end: vld %b done %b want 0 1", s.vld, done); end
  endtask

`ifdef PTX_XSHIFT_EN
  task automatic test_xshift();
    int cyc, herr, k; bit to;
    load_mem(0); build_exp(2);
    start_stream(2);
    collect(0, 64, cyc, herr, to);
    n_cmp++; if (to || got_d.size() != N) begin n_bad++; $display("FAIL xs2_count: beats %0d want %0d", got_d.size(), N); end
    n_cmp++; if (got_d.size() > 1 && (got_d[0] !== 64'hFFFF_FFFF_FFFF_FFF1 || got_d[1] !== 64'hFFFF_FFFF_FFFF_FFF0))
      begin n_bad++; $display("FAIL xs2_neg: got %h %h want fff..f1 fff..f0", got_d[0], got_d[1]); end
    for (int i = 0; i < got_d.size() && i < N; i++) begin
      n_cmp++; if (got_d[i] !== exp_q[i]) begin n_bad++; $display("FAIL xs2_beat%0d: got %h want %h", i, got_d[i], exp_q[i]); end
    end
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      k = $urandom_range(0, N - 1);
      load_mem(1); build_exp(k);
      start_stream(k);
      collect(2, 400, cyc, herr, to);
      n_cmp++; if (to || got_d.size() != N) begin n_bad++; $display("FAIL xsr_count: k %0d beats %0d want %0d", k, got_d.size(), N); end
      for (int i = 0; i < got_d.size() && i < N; i++) begin
        n_cmp++; if (got_d[i] !== exp_q[i]) begin n_bad++; $display("FAIL xsr_k%0d_beat%0d: got %h want %h", k, i, got_d[i], exp_q[i]); end
      end
    end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    s.rdy = 1'b0;
    test_reset();
    test_basic();
    @(posedge clk); #1;
    test_backpressure(1, 0);
    @(posedge clk); #1;
    test_backpressure(2, 1);
    @(posedge clk); #1;
    test_wr_err();
    @(posedge clk); #1;
    test_reset_mid();
    @(posedge clk); #1;
    test_write_with_start();
    @(posedge clk); #1;
    test_back_to_back();
`ifdef PTX_XSHIFT_EN
    @(posedge clk); #1;
    test_xshift();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
